// File: rtl/s1_pkg.sv
// s1_pkg: shared constants and FSM state encoding for the S1 serializer.
package s1_pkg;
   localparam int DW = 18;
   localparam int AW = 3;
   localparam int FRAME_LEN = 21;
   localparam int NUM_WORDS = 8;
   typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, DONE} state_t;
endpackage

// File: rtl/s1_shift21.sv
// s1_shift21: parallel-load, MSB-first shift register; zeros shift in at the LSB.
module s1_shift21 #(
   parameter int W = 21
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] d,
   output logic         sd
);
   logic [W-1:0] q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (load) q <= d;
      else if (shift) q <= {q[W-2:0], 1'b0};
   assign sd = q[W-1];
endmodule

// File: rtl/s1_serializer.sv
// s1_serializer: sends RB1 words 0..7 as {addr,data} MSB-first frames on sen/sd, two idle cycles apart.
// Define S1_START_EN to add a start input and an IDLE state that waits for it.
module s1_serializer #(
   parameter int DW = s1_pkg::DW,
   parameter int AW = s1_pkg::AW
) (
   input  logic          clk,
   input  logic          rst_n,
`ifdef S1_START_EN
   input  logic          start,
`endif
   output logic          S1_done,
   output logic          RB1_RW,
   output logic [AW-1:0] RB1_A,
   input  logic [DW-1:0] RB1_Q,
   output logic          sen,
   output logic          sd
);
   import s1_pkg::*;
`ifdef S1_START_EN
   localparam state_t RST_STATE = IDLE;
`else
   localparam state_t RST_STATE = FETCH;
`endif
   state_t state, state_d;
   logic [4:0] cnt, cnt_d;
   logic [AW-1:0] addr, addr_d;
   logic load, shift, last, msb;
   assign last = addr == {AW{1'b1}};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= RST_STATE;
         cnt <= 5'(FRAME_LEN - 1);
         addr <= '0;
      end else begin
         state <= state_d;
         cnt <= cnt_d;
         addr <= addr_d;
      end
   always_comb begin
      state_d = state;
      cnt_d = cnt;
      addr_d = addr;
      load = 1'b0;
      shift = 1'b0;
      case (state)
`ifdef S1_START_EN
         IDLE: state_d = start ? FETCH : IDLE;
`endif
         FETCH: state_d = LOAD;
         LOAD: begin
            state_d = SEND;
            cnt_d = 5'(FRAME_LEN - 1);
            load = 1'b1;
         end
         SEND: begin
            shift = cnt != '0;
            cnt_d = (cnt != '0) ? cnt - 5'd1 : cnt;
            state_d = (cnt != '0) ? SEND : (last ? DONE : FETCH);
            addr_d = (cnt == '0 && !last) ? addr + 1'b1 : addr;
         end
         default: ;
      endcase
   end
   s1_shift21 #(.W(AW + DW)) u_shift (
      .clk(clk),
      .rst_n(rst_n),
      .load(load),
      .shift(shift),
      .d({addr, RB1_Q}),
      .sd(msb)
   );
   // sen/sd decode straight from state so an async reset aborts the frame at once
   assign sen = state != SEND;
   assign sd = (state == SEND) & msb;
   assign S1_done = state == DONE;
   assign RB1_A = addr;
   assign RB1_RW = 1'b1;
endmodule

// File: tb/tb_s1_serializer.sv
// tb_s1_serializer: scoreboard bench reassembling serial frames and checking frame timing, reset and done.
module tb_s1_serializer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic S1_done, RB1_RW, sen, sd;
   logic [2:0] RB1_A;
   logic [17:0] RB1_Q;
   logic [17:0] mem [8];
   logic [17:0] rb2 [8];
   logic [20:0] exp_q [$];
   int checks = 0;
   int failures = 0;
   int c = 0;
   int prev_rise = 0;
   int rx_count = 0;

   s1_serializer dut (
      .clk(clk),
      .rst_n(rst_n),
      .S1_done(S1_done),
      .RB1_RW(RB1_RW),
      .RB1_A(RB1_A),
      .RB1_Q(RB1_Q),
      .sen(sen),
      .sd(sd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) RB1_Q <= mem[RB1_A];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      c++;
   endtask

   task automatic load_mem(input bit alt);
      exp_q.delete();
      for (int k = 0; k < 8; k++) begin
         mem[k] = alt ? 18'h2AAAA : 18'h3FFFF - 18'(k);
         exp_q.push_back({3'(k), mem[k]});
      end
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      c = 0;
      prev_rise = 0;
   endtask

   task automatic capture(input int k);
      logic [20:0] f, e;
      int len, idle, fall;
      bit bad;
      bad = 0;
      idle = 0;
      do begin
         step();
         idle++;
         if (sen === 1'b1) bad |= (sd !== 1'b0) || (RB1_RW !== 1'b1);
      end while (sen !== 1'b0 && idle < 60);
      fall = c;
      check($sformatf("fall_cycle[%0d]", k), fall, 23 * k + 2);
      check($sformatf("addr[%0d]", k), 32'(RB1_A), k);
      if (k > 0) check($sformatf("gap[%0d]", k), fall - prev_rise, 2);
      f = '0;
      len = 0;
      while (sen === 1'b0 && len < 40) begin
         f = {f[19:0], sd};
         len++;
         bad |= (RB1_RW !== 1'b1) || (S1_done !== 1'b0);
         step();
      end
      prev_rise = c;
      e = exp_q.size() > 0 ? exp_q.pop_front() : 21'h1FFFFF;
      check($sformatf("frame[%0d]", k), 32'(f), 32'(e));
      check($sformatf("len[%0d]", k), len, 21);
      check($sformatf("rise_cycle[%0d]", k), c, 23 * k + 23);
      check($sformatf("idle_sd_rw[%0d]", k), 32'(bad), 0);
      rb2[f[20:18]] = f[17:0];
      rx_count++;
   endtask

   initial begin
      bit bad;
      load_mem(0);
      @(negedge clk);
      check("rst_sen", 32'(sen), 1);
      check("rst_sd", 32'(sd), 0);
      check("rst_addr", 32'(RB1_A), 0);
      check("rst_rw", 32'(RB1_RW), 1);
      check("rst_done", 32'(S1_done), 0);
      release_reset();
      for (int k = 0; k < 8; k++) capture(k);
      check("done_cycle", c, 184);
      check("done_high", 32'(S1_done), 1);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         bad |= (sen !== 1'b1) || (sd !== 1'b0) || (RB1_A !== 3'd7) || (S1_done !== 1'b1);
      end
      check("done_stable", 32'(bad), 0);
      for (int k = 0; k < 8; k++) check($sformatf("rb2[%0d]", k), 32'(rb2[k]), 32'(mem[k]));
      check("s2_done", rx_count, 8);

      rst_n = 1'b0;
      load_mem(1);
      #1;
      check("rst2_done", 32'(S1_done), 0);
      check("rst2_addr", 32'(RB1_A), 0);
      release_reset();
      for (int k = 0; k < 3; k++) capture(k);
      while (c < 81) step();
      check("mid_sen_low", 32'(sen), 0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_sen", 32'(sen), 1);
      check("mid_rst_sd", 32'(sd), 0);
      check("mid_rst_addr", 32'(RB1_A), 0);
      check("mid_rst_done", 32'(S1_done), 0);
      load_mem(1);
      release_reset();
      capture(0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
